synth_write_arbiter: RTL

- Shares the synth core's single register-write port (4-bit address, 8-bit data, strobe) between two requesters, e.g. the note sequencer and the host/UART command path.
- Arbitrates round-robin and paces each write as a strobe pulse followed by a data-stable gap.
- Supports a lock, so multi-register updates (e.g. an even/odd register pair) reach the synth without interleaving.
- Sits between the requesters and the synth core's ui_in / uio_in write inputs.

---
 rtl/synth_write_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/synth_write_arbiter.sv
// rtl/synth_write_arbiter.sv - round-robin, lockable arbiter for the synth core's register-write port
module synth_write_arbiter #(
  parameter int ADDR_BITS    = 4,
  parameter int DATA_BITS    = 8,
  parameter int STROBE_LEN   = 1,
  parameter int GAP_LEN      = 9,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 r0_valid_i,
  output logic                 r0_ready_o,
  input  logic [ADDR_BITS-1:0] r0_addr_i,
  input  logic [DATA_BITS-1:0] r0_data_i,
  input  logic                 r0_lock_i,
  input  logic                 r1_valid_i,
  output logic                 r1_ready_o,
  input  logic [ADDR_BITS-1:0] r1_addr_i,
  input  logic [DATA_BITS-1:0] r1_data_i,
  input  logic                 r1_lock_i,
  output logic                 syn_strobe_o,
  output logic [ADDR_BITS-1:0] syn_addr_o,
  output logic [DATA_BITS-1:0] syn_data_o,
  output logic                 busy_o,
  output logic [1:0]           lock_owner_o
);

  typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;

  localparam int MAX_LEN = (STROBE_LEN > GAP_LEN) ? STROBE_LEN : GAP_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [TMR_W-1:0] timer;
  logic             locked, owner, last_grant;
  logic             grant, grant_valid, hs, owner_valid;

  // While locked, only the owner is eligible; otherwise a tie goes to whoever did not win last.
  always_comb begin
    grant       = 1'b0;
    grant_valid = 1'b0;
    if (locked) begin
      grant       = owner;
      grant_valid = owner ? r1_valid_i : r0_valid_i;
    end else if (r0_valid_i && r1_valid_i) begin
      grant       = ~last_grant;
      grant_valid = 1'b1;
    end else if (r1_valid_i) begin
      grant       = 1'b1;
      grant_valid = 1'b1;
    end else if (r0_valid_i) begin
      grant       = 1'b0;
      grant_valid = 1'b1;
    end
  end

  assign r0_ready_o  = (state == IDLE) && rst_n && grant_valid && !grant;
  assign r1_ready_o  = (state == IDLE) && rst_n && grant_valid && grant;
  assign hs          = r0_ready_o || r1_ready_o;
  assign owner_valid = owner ? r1_valid_i : r0_valid_i;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (hs) begin
          state_next = STROBE;
          cnt_next   = '0;
        end
      end
      STROBE: begin
        if (cnt == CNT_W'(STROBE_LEN - 1)) begin
          state_next = GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_LEN - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      syn_addr_o <= '0;
      syn_data_o <= '0;
      last_grant <= 1'b1;
      locked     <= 1'b0;
      owner      <= 1'b0;
      timer      <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (hs) begin
        syn_addr_o <= grant ? r1_addr_i : r0_addr_i;
        syn_data_o <= grant ? r1_data_i : r0_data_i;
        last_grant <= grant;
        locked     <= grant ? r1_lock_i : r0_lock_i;
        owner      <= grant;
      end
      // An idle lock whose owner has gone quiet is released once the timer expires.
      if (state != IDLE || !locked || owner_valid) begin
        timer <= '0;
      end else if (LOCK_TIMEOUT != 0) begin
        if (timer == TMR_W'(LOCK_TIMEOUT - 1)) begin
          locked <= 1'b0;
          timer  <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  assign syn_strobe_o = (state == STROBE);
  assign busy_o       = (state != IDLE);
  assign lock_owner_o = {locked, owner};

endmodule
